// File: rtl/bitty_fetch.sv
// bitty_fetch: instruction fetch/issue sequencer for the bitty core.
// It walks the program counter from 0 to a latched last address. For each
// instruction it reads the synchronous instruction memory, hands the word
// to the core with a run pulse, and waits for the core's done pulse.
module bitty_fetch #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic [15:0]       d_instr,
  output logic              run,
  input  logic              done,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       retired,
  output logic [2:0]        dbg_state
);

  // Core handshake: run is a single-cycle request carrying d_instr, and done
  // is the single-cycle completion for it. Exactly one request can be
  // outstanding. done only counts while in S_EXEC; any other done (early,
  // late, or for an instruction issued before a reset) is dropped.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_ISSUE = 3'd3,
    S_EXEC  = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] last_q;
  logic [15:0]       ir;
  logic [15:0]       ret_q;
  logic              start_ok;
  logic              done_ok;
  logic              at_last;

  // A start counts only from IDLE or HALT, and a done only from EXEC.
  assign start_ok = ((state == S_IDLE) || (state == S_HALT)) && start;
  assign done_ok  = (state == S_EXEC) && done;
  assign at_last  = (pc == last_q);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. FETCH, LOAD and ISSUE each last exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_EXEC;
      S_EXEC:  if (done) state_nxt = at_last ? S_HALT : S_FETCH;
      S_HALT:  if (start) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: pc, latched last address, instruction register and retire count.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= '0;
      last_q <= '0;
      ir     <= 16'h0000;
      ret_q  <= 16'h0000;
    end else begin
      if (start_ok) begin
        pc     <= '0;
        last_q <= last_addr;
        ret_q  <= 16'h0000;
      end
      // Memory data is valid in the cycle after the FETCH strobe, i.e. in LOAD.
      if (state == S_LOAD) begin
        ir <= mem_data;
      end
      if (done_ok) begin
        if (ret_q != 16'hFFFF) begin
          ret_q <= ret_q + 16'd1;
        end
        // pc stays on the final address when the program halts.
        if (!at_last) begin
          pc <= pc + ADDR_W'(1);
        end
      end
    end
  end

  assign mem_en    = (state == S_FETCH);
  assign mem_addr  = pc;
  assign run       = (state == S_ISSUE);
  assign d_instr   = ir;
  assign busy      = (state != S_IDLE) && (state != S_HALT);
  assign halted    = (state == S_HALT);
  assign retired   = ret_q;
  assign dbg_state = state;

endmodule
